// File: rtl/truth_table_scanner_pkg.sv
// Shared constants for the truth-table scanner: code space, result widths
// and the FSM state encoding.
package truth_table_scanner_pkg;

    localparam int N_CODES = 16;
    localparam int CODE_W  = 4;
    localparam int ONES_W  = 5;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SCAN   = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    // Last code of the scan; sampling it ends the SCAN phase.
    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(N_CODES - 1);

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle counter: counts clocks while enabled and flags the last settle
// cycle of the current code. Clears itself on that flag so the next code
// starts a fresh settle window.
module scan_settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick marks the sample edge of the code currently being held.
    always_comb begin
        tick = en && (cnt_q == LAST);
    end

    // Next count: clear on request or at the sample edge, else step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives all 16 {A,B,C,D} codes into an external
// combinational block, holds each for SETTLE_CYCLES clocks, samples y_i at
// the end of each window and builds a 16-bit truth vector plus ones count.
//
// Handshake: start is a request that is only taken while idle (busy=0);
// it is not queued. busy stays high from the accepting edge through the
// done cycle. done is a one-cycle pulse; truth_o/ones_o are valid from
// that cycle onwards and hold until the next accepted start or reset.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [CODE_W-1:0]  abcd_o,
    input  logic               y_i,
    output logic               busy,
    output logic               done,
    output logic [N_CODES-1:0] truth_o,
    output logic [ONES_W-1:0]  ones_o,
    output logic [1:0]         state_dbg_o
);

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   abcd_q, abcd_d;
    logic [N_CODES-1:0]  truth_q, truth_d;
    logic [ONES_W-1:0]   ones_q, ones_d;

    logic timer_clr;
    logic timer_en;
    logic sample;

    scan_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tick  (sample)
    );

    // Timer only runs during SCAN; it sits at zero in every other state.
    always_comb begin
        timer_en  = (state_q == ST_SCAN);
        timer_clr = (state_q != ST_SCAN);
    end

    // FSM, code stepping and capture/popcount.
    always_comb begin
        state_d = state_q;
        abcd_d  = abcd_q;
        truth_d = truth_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    truth_d = '0;
                    ones_d  = '0;
                    abcd_d  = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sample) begin
                    truth_d[abcd_q] = y_i;
                    ones_d          = ones_q + ONES_W'(y_i);
                    // Wraps to 0 after the last code.
                    abcd_d          = abcd_q + CODE_W'(1);
                    if (abcd_q == LAST_CODE) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            abcd_q  <= '0;
            truth_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            abcd_q  <= abcd_d;
            truth_q <= truth_d;
            ones_q  <= ones_d;
        end
    end

    // Outputs are decoded straight from registers, so they are glitch-free.
    always_comb begin
        abcd_o      = abcd_q;
        truth_o     = truth_q;
        ones_o      = ones_q;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FINISH);
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner. Two instances: SETTLE_CYCLES=2
// (sel=0) and SETTLE_CYCLES=1 (sel=1). The Y2 block is modelled in the
// bench by a selectable function of the code each instance drives.
module tb_truth_table_scanner;
    import truth_table_scanner_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        start;
    logic        sel;
    int          y_mode;   // 0:const0 1:const1 2:(A&B)|(C&D) 3:D 4:A

    logic        start2, start1;
    logic [3:0]  abcd2, abcd1;
    logic        y2, y1;
    logic        busy2, busy1, done2, done1;
    logic [15:0] truth2, truth1;
    logic [4:0]  ones2, ones1;
    logic [1:0]  st2, st1;

    logic [3:0]  abcd_obs;
    logic        busy_obs, done_obs;
    logic [15:0] truth_obs;
    logic [4:0]  ones_obs;
    logic [1:0]  st_obs;

    int vec_cnt;
    int err_cnt;

    function automatic logic y_fn(input int m, input logic [3:0] c);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (c[3] & c[2]) | (c[1] & c[0]);
            3:       return c[0];
            4:       return c[3];
            default: return 1'b0;
        endcase
    endfunction

    assign start2 = start & ~sel;
    assign start1 = start & sel;
    assign y2 = y_fn(y_mode, abcd2);
    assign y1 = y_fn(y_mode, abcd1);

    assign abcd_obs  = sel ? abcd1  : abcd2;
    assign busy_obs  = sel ? busy1  : busy2;
    assign done_obs  = sel ? done1  : done2;
    assign truth_obs = sel ? truth1 : truth2;
    assign ones_obs  = sel ? ones1  : ones2;
    assign st_obs    = sel ? st1    : st2;

    truth_table_scanner #(.SETTLE_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abcd_o(abcd2), .y_i(y2),
        .busy(busy2), .done(done2), .truth_o(truth2), .ones_o(ones2),
        .state_dbg_o(st2)
    );

    truth_table_scanner #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abcd_o(abcd1), .y_i(y1),
        .busy(busy1), .done(done1), .truth_o(truth1), .ones_o(ones1),
        .state_dbg_o(st1)
    );

    // ---------------- driver tasks ----------------
    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge from idle; returns just after accept edge t0.
    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tick until done is seen (bounded). cyc = edges after t0 (-1 on timeout),
    // busy_cyc = cycles with busy high, counting the cycle right after t0.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = -1;
        busy_cyc = busy_obs ? 1 : 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (busy_obs) busy_cyc++;
            if (done_obs) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vec_cnt++;
            if (abcd_obs !== 4'd0 || busy_obs !== 1'b0 || done_obs !== 1'b0 ||
                truth_obs !== 16'h0 || ones_obs !== 5'd0 || st_obs !== ST_IDLE) begin
                err_cnt++;
                $display("FAIL reset sel=%0d: abcd=%0d busy=%b done=%b truth=%h ones=%0d st=%0d, need all zero/idle",
                         s, abcd_obs, busy_obs, done_obs, truth_obs, ones_obs, st_obs);
            end
        end
        sel = 1'b0;
        tick();
    endtask

    task automatic test_andor_scan();
        int n;
        sel = 1'b0;
        y_mode = 2;
        launch();
        vec_cnt++;
        if (busy_obs !== 1'b1 || abcd_obs !== 4'd0 || st_obs !== ST_SCAN) begin
            err_cnt++;
            $display("FAIL andor accept: busy=%b abcd=%0d st=%0d, need 1/0/%0d",
                     busy_obs, abcd_obs, st_obs, ST_SCAN);
        end
        for (n = 1; n <= 32; n++) begin
            tick();
            vec_cnt++;
            if (n < 32) begin
                if (abcd_obs !== 4'((n / 2) % 16) || done_obs !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL andor step n=%0d: abcd=%0d done=%b, need %0d/0",
                             n, abcd_obs, done_obs, (n / 2) % 16);
                end
            end else begin
                if (abcd_obs !== 4'd0 || done_obs !== 1'b1 || st_obs !== ST_FINISH) begin
                    err_cnt++;
                    $display("FAIL andor done n=32: abcd=%0d done=%b st=%0d, need 0/1/%0d",
                             abcd_obs, done_obs, st_obs, ST_FINISH);
                end
            end
        end
        vec_cnt++;
        if (truth_obs !== 16'hF888 || ones_obs !== 5'd7) begin
            err_cnt++;
            $display("FAIL andor result: truth=%h ones=%0d, need f888/7", truth_obs, ones_obs);
        end
        tick();
        tick();
        tick();
        vec_cnt++;
        if (done_obs !== 1'b0 || busy_obs !== 1'b0 || truth_obs !== 16'hF888 ||
            ones_obs !== 5'd7 || abcd_obs !== 4'd0) begin
            err_cnt++;
            $display("FAIL andor hold: done=%b busy=%b truth=%h ones=%0d abcd=%0d, need 0/0/f888/7/0",
                     done_obs, busy_obs, truth_obs, ones_obs, abcd_obs);
        end
    endtask

    task automatic test_const_scans();
        int cyc, bc;
        sel = 1'b0;
        y_mode = 0;
        launch();
        wait_done(cyc, bc);
        vec_cnt++;
        if (cyc !== 32 || truth_obs !== 16'h0000 || ones_obs !== 5'd0) begin
            err_cnt++;
            $display("FAIL zeros: cyc=%0d truth=%h ones=%0d, need 32/0000/0", cyc, truth_obs, ones_obs);
        end
        tick();
        y_mode = 1;
        launch();
        wait_done(cyc, bc);
        vec_cnt++;
        if (cyc !== 32 || truth_obs !== 16'hFFFF || ones_obs !== 5'd16) begin
            err_cnt++;
            $display("FAIL ones: cyc=%0d truth=%h ones=%0d, need 32/ffff/16", cyc, truth_obs, ones_obs);
        end
        tick();
        // A new accepted start wipes the all-ones result.
        y_mode = 0;
        launch();
        vec_cnt++;
        if (truth_obs !== 16'h0000 || ones_obs !== 5'd0) begin
            err_cnt++;
            $display("FAIL clear on start: truth=%h ones=%0d, need 0000/0", truth_obs, ones_obs);
        end
        wait_done(cyc, bc);
        tick();
    endtask

    task automatic test_fast_settle();
        int cyc, bc;
        sel = 1'b1;
        y_mode = 3;
        launch();
        wait_done(cyc, bc);
        vec_cnt++;
        if (cyc !== 16 || truth_obs !== 16'hAAAA || ones_obs !== 5'd8) begin
            err_cnt++;
            $display("FAIL settle1: cyc=%0d truth=%h ones=%0d, need 16/aaaa/8", cyc, truth_obs, ones_obs);
        end
        tick();
        if (busy_obs) bc++;
        vec_cnt++;
        if (bc !== 17 || busy_obs !== 1'b0 || done_obs !== 1'b0) begin
            err_cnt++;
            $display("FAIL settle1 busy: busy_cycles=%0d busy=%b done=%b, need 17/0/0",
                     bc, busy_obs, done_obs);
        end
        sel = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        sel = 1'b0;
        y_mode = 4;
        start = 1'b1;
        tick();
        wait_done(cyc, bc);
        vec_cnt++;
        if (cyc !== 32 || truth_obs !== 16'hFF00 || ones_obs !== 5'd8) begin
            err_cnt++;
            $display("FAIL b2b first: cyc=%0d truth=%h ones=%0d, need 32/ff00/8", cyc, truth_obs, ones_obs);
        end
        tick();
        vec_cnt++;
        if (busy_obs !== 1'b0 || done_obs !== 1'b0 || st_obs !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL b2b idle gap: busy=%b done=%b st=%0d, need 0/0/idle", busy_obs, done_obs, st_obs);
        end
        tick();
        vec_cnt++;
        if (busy_obs !== 1'b1 || truth_obs !== 16'h0000 || abcd_obs !== 4'd0) begin
            err_cnt++;
            $display("FAIL b2b reaccept: busy=%b truth=%h abcd=%0d, need 1/0000/0", busy_obs, truth_obs, abcd_obs);
        end
        wait_done(cyc, bc);
        start = 1'b0;
        vec_cnt++;
        if (cyc !== 32 || truth_obs !== 16'hFF00 || ones_obs !== 5'd8) begin
            err_cnt++;
            $display("FAIL b2b second: cyc=%0d truth=%h ones=%0d, need 32/ff00/8", cyc, truth_obs, ones_obs);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_abort();
        int done_seen;
        bit reached;
        sel = 1'b0;
        y_mode = 2;
        reached = 1'b0;
        launch();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (abcd_obs == 4'd9) begin
                reached = 1'b1;
                break;
            end
        end
        vec_cnt++;
        if (!reached || truth_obs !== 16'h0088 || ones_obs !== 5'd2) begin
            err_cnt++;
            $display("FAIL abort pre: reached=%b truth=%h ones=%0d, need 1/0088/2", reached, truth_obs, ones_obs);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec_cnt++;
        if (abcd_obs !== 4'd0 || busy_obs !== 1'b0 || truth_obs !== 16'h0 ||
            ones_obs !== 5'd0 || done_obs !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort post: abcd=%0d busy=%b truth=%h ones=%0d done=%b, need 0/0/0000/0/0",
                     abcd_obs, busy_obs, truth_obs, ones_obs, done_obs);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_obs) done_seen++;
        end
        vec_cnt++;
        if (done_seen !== 0 || busy_obs !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort no done: done_pulses=%0d busy=%b, need 0/0", done_seen, busy_obs);
        end
    endtask

    task automatic test_start_midscan();
        int n;
        bit pulsed;
        sel = 1'b0;
        y_mode = 2;
        pulsed = 1'b0;
        n = -1;
        launch();
        for (int i = 1; i <= 200; i++) begin
            tick();
            start = 1'b0;
            if (done_obs) begin
                n = i;
                break;
            end
            if (!pulsed && abcd_obs == 4'd5) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        vec_cnt++;
        if (n !== 32 || !pulsed || truth_obs !== 16'hF888 || ones_obs !== 5'd7) begin
            err_cnt++;
            $display("FAIL midscan start: cyc=%0d pulsed=%b truth=%h ones=%0d, need 32/1/f888/7",
                     n, pulsed, truth_obs, ones_obs);
        end
        tick();
        tick();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        y_mode  = 0;
        test_reset();
        test_andor_scan();
        test_const_scans();
        test_fast_settle();
        test_back_to_back();
        test_reset_abort();
        test_start_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
